// File: rtl/bcd_entry_reg_pkg.sv
// Shared constants and types for the keypad BCD entry register.
// Optional blanking of unused digit positions is enabled with BCD_ENTRY_BLANK_EN.
package bcd_entry_reg_pkg;

  localparam int         NUM_DIGITS_DEF = 4;
  localparam logic [3:0] BCD_ZERO       = 4'd0;
  localparam logic [3:0] BCD_NULL       = 4'd13;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_DIGIT     = 3'd1,
    CMD_BKSP      = 3'd2,
    CMD_CLEAR     = 3'd3,
    CMD_COMMIT    = 3'd4,
    CMD_SWAP      = 3'd5,
    CMD_CLEAR_ALL = 3'd6,
    CMD_RSVD      = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } entry_st_e;

  typedef struct packed {
    logic clr;
    logic load;
    logic shl;
    logic shr;
  } shift_op_t;

endpackage

// File: rtl/bcd_shift_reg.sv
// Digit shift register holding NUM_DIGITS BCD digits, digit 0 in the low nibble.
// Priority: reset/clear, load, shift-left-insert, shift-right.
module bcd_shift_reg
  import bcd_entry_reg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  shift_op_t               i_op,
  input  logic [3:0]              i_ins_digit,
  input  logic [4*NUM_DIGITS-1:0] i_load_val,
  output logic [4*NUM_DIGITS-1:0] o_digits
);

  logic [4*NUM_DIGITS-1:0] r_digits;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_op.clr) begin
      r_digits <= '0;
    end else if (i_op.load) begin
      r_digits <= i_load_val;
    end else if (i_op.shl) begin
      // Top digit is known zero here because shifting only happens below full.
      r_digits <= {r_digits[4*NUM_DIGITS-5:0], i_ins_digit};
    end else if (i_op.shr) begin
      r_digits <= {BCD_ZERO, r_digits[4*NUM_DIGITS-1:4]};
    end
  end

  assign o_digits = r_digits;

endmodule

// File: rtl/bcd_entry_reg.sv
// Keypad BCD digit-entry register with backspace, clear, commit and swap.
// Define BCD_ENTRY_BLANK_EN to show BCD_NULL in positions beyond each field's length.
module bcd_entry_reg
  import bcd_entry_reg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int LEN_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  input  logic [2:0]              i_cmd,
  input  logic [3:0]              i_key_digit,
  output logic [4*NUM_DIGITS-1:0] o_entry,
  output logic [4*NUM_DIGITS-1:0] o_operand,
  output logic [LEN_W-1:0]        o_len,
  output logic                    o_full,
  output logic                    o_overflow,
  output logic                    o_bad_digit,
  output logic                    o_commit_pulse
);

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(NUM_DIGITS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  function automatic logic [LEN_W-1:0] sig_len(input logic [4*NUM_DIGITS-1:0] v);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] != BCD_ZERO) n = LEN_W'(i + 1);
    end
    return n;
  endfunction

  logic [LEN_W-1:0]        r_len;
  logic [4*NUM_DIGITS-1:0] r_operand;
  logic                    r_overflow;
  logic                    r_bad_digit;
  logic                    r_commit;

  logic [4*NUM_DIGITS-1:0] w_entry_raw;
  entry_st_e               w_state;
  cmd_e                    w_cmd;
  shift_op_t               w_op;
  logic [LEN_W-1:0]        w_len_nxt;
  logic                    w_op_wr;
  logic [4*NUM_DIGITS-1:0] w_op_nxt;
  logic                    w_ovf_nxt;
  logic                    w_bad_nxt;
  logic                    w_commit_nxt;

  assign w_cmd   = cmd_e'(i_cmd);
  assign w_state = (r_len == '0)      ? ST_EMPTY :
                   (r_len == LEN_FULL) ? ST_FULL  : ST_ENTRY;

  always_comb begin
    w_op         = '0;
    w_len_nxt    = r_len;
    w_op_wr      = 1'b0;
    w_op_nxt     = r_operand;
    w_ovf_nxt    = 1'b0;
    w_bad_nxt    = 1'b0;
    w_commit_nxt = 1'b0;
    if (i_cmd_valid) begin
      case (w_cmd)
        CMD_DIGIT: begin
          if (i_key_digit > BCD_MAX) begin
            w_bad_nxt = 1'b1;
          end else begin
            case (w_state)
              ST_EMPTY: begin
                // Leading zeros are dropped so the field never starts with 0.
                if (i_key_digit != BCD_ZERO) begin
                  w_op.shl  = 1'b1;
                  w_len_nxt = LEN_ONE;
                end
              end
              ST_ENTRY: begin
                w_op.shl  = 1'b1;
                w_len_nxt = r_len + LEN_ONE;
              end
              default: w_ovf_nxt = 1'b1;
            endcase
          end
        end
        CMD_BKSP: begin
          if (w_state != ST_EMPTY) begin
            w_op.shr  = 1'b1;
            w_len_nxt = r_len - LEN_ONE;
          end
        end
        CMD_CLEAR: begin
          w_op.clr  = 1'b1;
          w_len_nxt = '0;
        end
        CMD_COMMIT: begin
          w_op.clr     = 1'b1;
          w_len_nxt    = '0;
          w_op_wr      = 1'b1;
          w_op_nxt     = w_entry_raw;
          w_commit_nxt = 1'b1;
        end
        CMD_SWAP: begin
          w_op.load    = 1'b1;
          w_len_nxt    = sig_len(r_operand);
          w_op_wr      = 1'b1;
          w_op_nxt     = w_entry_raw;
          w_commit_nxt = 1'b1;
        end
        CMD_CLEAR_ALL: begin
          w_op.clr  = 1'b1;
          w_len_nxt = '0;
          w_op_wr   = 1'b1;
          w_op_nxt  = '0;
        end
        default: ;
      endcase
    end
  end

  bcd_shift_reg #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_entry (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_op        (w_op),
    .i_ins_digit (i_key_digit),
    .i_load_val  (r_operand),
    .o_digits    (w_entry_raw)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len       <= '0;
      r_operand   <= '0;
      r_overflow  <= 1'b0;
      r_bad_digit <= 1'b0;
      r_commit    <= 1'b0;
    end else begin
      r_len       <= w_len_nxt;
      r_overflow  <= w_ovf_nxt;
      r_bad_digit <= w_bad_nxt;
      r_commit    <= w_commit_nxt;
      if (w_op_wr) r_operand <= w_op_nxt;
    end
  end

`ifdef BCD_ENTRY_BLANK_EN
  logic [LEN_W-1:0] r_op_len;

  // The operand inherits the entry's length on COMMIT/SWAP, so no recount is needed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_len <= '0;
    end else if (i_cmd_valid && (w_cmd == CMD_COMMIT || w_cmd == CMD_SWAP)) begin
      r_op_len <= r_len;
    end else if (i_cmd_valid && w_cmd == CMD_CLEAR_ALL) begin
      r_op_len <= '0;
    end
  end

  function automatic logic [4*NUM_DIGITS-1:0] blank(input logic [4*NUM_DIGITS-1:0] v,
                                                    input logic [LEN_W-1:0]        n);
    logic [4*NUM_DIGITS-1:0] o;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      o[4*i +: 4] = (i != 0 && LEN_W'(i) >= n) ? BCD_NULL : v[4*i +: 4];
    end
    return o;
  endfunction

  assign o_entry   = blank(w_entry_raw, r_len);
  assign o_operand = blank(r_operand, r_op_len);
`else
  assign o_entry   = w_entry_raw;
  assign o_operand = r_operand;
`endif

  assign o_len          = r_len;
  assign o_full         = (r_len == LEN_FULL);
  assign o_overflow     = r_overflow;
  assign o_bad_digit    = r_bad_digit;
  assign o_commit_pulse = r_commit;

endmodule

// File: doc/bcd_entry_reg.md
# bcd_entry_reg

Parametrised keypad digit-entry register for the calculator datapath: it sits between the keypad decoder and the seven-segment/ALU stage. It collects up to NUM_DIGITS BCD digits into an entry field and supports backspace, clear, commit and swap. A committed value is held in a separate operand register. Length tracking, overflow and invalid-digit reporting replace the fixed 4-digit, select-driven behaviour of the previous generation.

## Interface
- NUM_DIGITS, 4, digits per field (2..8)
- LEN_W, $clog2(NUM_DIGITS+1), width of len
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe, one command per cycle
- cmd  in  3  0 NOP, 1 DIGIT, 2 BKSP, 3 CLEAR, 4 COMMIT, 5 SWAP, 6 CLEAR_ALL, 7 reserved (NOP)
- key_digit  in  4  BCD digit for DIGIT
- entry  out  4*NUM_DIGITS  entry field, digit 0 in bits [3:0]
- operand  out  4*NUM_DIGITS  committed field
- len  out  LEN_W  significant digits in entry
- full  out  1  len == NUM_DIGITS
- overflow  out  1  one-cycle pulse: DIGIT rejected because full
- bad_digit  out  1  one-cycle pulse: DIGIT with key_digit > 9
- commit_pulse  out  1  one-cycle pulse after COMMIT or SWAP executes

## Operation
- States: EMPTY (len=0), ENTRY (0<len<N), FULL (len=N); derived from len, no extra state register.
- DIGIT d (d<=9): EMPTY & d=0 -> no change (no leading zeros). EMPTY & d>0 -> digit0=d, len=1 -> ENTRY. ENTRY -> shift left one digit, digit0=d, len+1; reaching N -> FULL. FULL -> no change, overflow=1.
- DIGIT d>9: no change in any state, bad_digit=1 (takes precedence over overflow).
- BKSP: shift right one digit, top digit=0, len-1; EMPTY -> no change.
- CLEAR: entry=0, len=0; operand kept.
- COMMIT: operand<=entry, entry=0, len=0, commit_pulse=1. Allowed from EMPTY (operand becomes 0).
- SWAP: entry<->operand exchanged in one cycle; len recomputed as index of highest nonzero operand digit +1 (0 if operand=0); commit_pulse=1.
- CLEAR_ALL: entry, operand, len=0.
- cmd_valid=0 or cmd=7: hold everything, pulses 0.
- Stored digits above len are always 0.

## Timing
- All outputs registered; command at edge k visible after edge k (1-cycle latency).
- Pulses high exactly one cycle, in the cycle after the offending/committing command.
- Back-to-back commands every cycle supported, no stall.
- rst: entry=0, operand=0, len=0, full=0, overflow=0, bad_digit=0, commit_pulse=0; rst wins over any same-cycle command; mid-entry reset discards partial entry and operand.

## Configuration
- BCD_ENTRY_BLANK_EN defined: entry and operand outputs show BCD_NULL (4'd13) in positions >= significant length; position 0 always shows its digit (so empty shows "0"). Operand length tracked in an extra register written on COMMIT/SWAP/CLEAR_ALL/rst.
- Not defined: unused positions output BCD_ZERO; no operand length register.

## Structure
- Shared package/global include: BCD_ZERO (4'd0), BCD_NULL (4'd13), CMD_* encodings, NUM_DIGITS default.
- One sub-module: bcd_shift_reg (NUM_DIGITS digits; load, shift-left-insert, shift-right, clear); instantiated for entry; operand is a plain register.
- Top holds len counter, command decode, pulse registers, optional blanking.

## Test plan
- rst, then DIGIT 0 -> entry=0000, len=0; DIGIT 1,2,3 -> entry=0123, len=3, full=0.
- From 0123: DIGIT 4 -> 1234, full=1; DIGIT 5 -> 1234 held, overflow=1 for one cycle; DIGIT 12 -> bad_digit=1, overflow=0.
- 1234: BKSP x2 -> 0012, len=2; BKSP x3 -> 0000, len=0, no underflow.
- Enter 56, COMMIT -> operand=0056, entry=0000, commit_pulse=1; enter 7, SWAP -> entry=0056 len=2, operand=0007.
- DIGIT 9 on same edge as rst=1 -> all outputs 0; CLEAR_ALL after filled fields -> both 0000.
- BCD_ENTRY_BLANK_EN: enter 42 -> entry digits {13,13,4,2}; empty -> {13,13,13,0}.
